// File: rtl/mul_operand_sequencer.sv
// Front end for the repeated-addition multiplier core: accepts an operand
// pair, starts the core, steers A then B onto its data bus, waits for done
// under a watchdog, returns the product and clears the core afterwards.
// Zero operands are answered directly without starting the core.
module mul_operand_sequencer #(
    parameter int unsigned W           = 16,
    parameter int unsigned PW          = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          mul_start,
    output logic          mul_clr,
    input  logic          mul_ld_a,
    input  logic          mul_ld_b,
    input  logic          mul_done,
    input  logic [PW-1:0] mul_product,
    output logic [W-1:0]  mul_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_product,
    output logic          out_bypass,
    output logic          out_err,
    output logic          busy
);

    localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_CLR   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q;
    logic [PW-1:0]  res_q;
    logic           byp_q, err_q;
    logic [CW-1:0]  cnt_q;

    logic load_ops, set_bypass, cap_done, set_timeout, clr_flags;
    logic cnt_clr, cnt_inc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath strobes and state-decoded outputs
    always_comb begin
        state_d     = state_q;
        load_ops    = 1'b0;
        set_bypass  = 1'b0;
        cap_done    = 1'b0;
        set_timeout = 1'b0;
        clr_flags   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        in_ready    = 1'b0;
        mul_start   = 1'b0;
        mul_clr     = rst;
        out_valid   = 1'b0;
        busy        = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    load_ops = 1'b1;
                    if ((in_a == '0) || (in_b == '0)) begin
                        set_bypass = 1'b1;
                        state_d    = S_OUT;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                mul_start = 1'b1;
                cnt_clr   = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over a coincident watchdog expiry
                if (mul_done) begin
                    cap_done = 1'b1;
                    state_d  = S_OUT;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    set_timeout = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    clr_flags = 1'b1;
                    state_d   = byp_q ? S_IDLE : S_CLR;
                end
            end
            S_CLR: begin
                mul_clr = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand, result, flag and watchdog registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            byp_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (load_ops) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            if (set_bypass) begin
                res_q <= '0;
                byp_q <= 1'b1;
                err_q <= 1'b0;
            end
            if (cap_done) begin
                res_q <= mul_product;
            end
            if (set_timeout) begin
                res_q <= '0;
                err_q <= 1'b1;
            end
            if (clr_flags) begin
                res_q <= '0;
                byp_q <= 1'b0;
                err_q <= 1'b0;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Shared core data bus; A wins if both strobes are high
    always_comb begin
        mul_data = '0;
        if (mul_ld_a) begin
            mul_data = a_q;
        end else if (mul_ld_b) begin
            mul_data = b_q;
        end
    end

    assign out_product = res_q;
    assign out_bypass  = byp_q;
    assign out_err     = err_q;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Bench for mul_operand_sequencer: behavioural core model, scoreboard,
// vector table, hand-written corner sequences and randomized operations.
module tb_mul_operand_sequencer;

    localparam int unsigned W  = 16;
    localparam int unsigned PW = 16;
    localparam int unsigned TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  in_a, in_b;
    logic          mul_start, mul_clr, mul_ld_a, mul_ld_b, mul_done;
    logic [PW-1:0] mul_product;
    logic [W-1:0]  mul_data;
    logic          out_valid, out_ready;
    logic [PW-1:0] out_product;
    logic          out_bypass, out_err, busy;

    mul_operand_sequencer #(.W(W), .PW(PW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_clr(mul_clr),
        .mul_ld_a(mul_ld_a), .mul_ld_b(mul_ld_b), .mul_done(mul_done),
        .mul_product(mul_product), .mul_data(mul_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .out_bypass(out_bypass), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [PW-1:0] p;
        logic          byp;
        logic          err;
    } exp_t;

    // Reference: zero operand -> bypass 0; hung core -> error 0; else a*b mod 2^PW
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit hang);
        exp_t e;
        if (a == 0 || b == 0) begin
            e.p = '0; e.byp = 1'b1; e.err = 1'b0;
        end else if (hang) begin
            e.p = '0; e.byp = 1'b0; e.err = 1'b1;
        end else begin
            e.p = PW'(32'(a) * 32'(b)); e.byp = 1'b0; e.err = 1'b0;
        end
        return e;
    endfunction

    // ---------------- behavioural core model ----------------
    bit            core_hang = 1'b0;
    int            core_delay = 2;
    logic          force_a = 1'b0, force_b = 1'b0;
    logic          core_ld_a, core_ld_b, core_done;
    logic [PW-1:0] core_prod;
    logic [W-1:0]  core_a;
    int            core_phase, core_cnt;
    logic [W-1:0]  last_a, last_b;

    assign mul_ld_a    = core_ld_a | force_a;
    assign mul_ld_b    = core_ld_b | force_b;
    assign mul_done    = core_done;
    assign mul_product = core_prod;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_phase <= 0; core_ld_a <= 1'b0; core_ld_b <= 1'b0;
            core_done <= 1'b0; core_prod <= '0; core_cnt <= 0; core_a <= '0;
        end else if (mul_clr) begin
            core_phase <= 0; core_ld_a <= 1'b0; core_ld_b <= 1'b0; core_done <= 1'b0;
        end else begin
            case (core_phase)
                0: if (mul_start) begin core_ld_a <= 1'b1; core_phase <= 1; end
                1: begin
                    chk("mul_data_a", mul_data, last_a);
                    core_a <= mul_data; core_ld_a <= 1'b0; core_ld_b <= 1'b1; core_phase <= 2;
                end
                2: begin
                    chk("mul_data_b", mul_data, last_b);
                    core_prod <= PW'(32'(core_a) * 32'(mul_data));
                    core_ld_b <= 1'b0; core_cnt <= core_delay; core_phase <= 3;
                end
                3: if (!core_hang) begin
                    if (core_cnt == 0) begin core_done <= 1'b1; core_phase <= 4; end
                    else core_cnt <= core_cnt - 1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard / event monitor ----------------
    exp_t          exp_q[$];
    logic [PW-1:0] out_log[$];
    int acc_cnt = 0, out_cnt = 0, start_cnt = 0, clr_cnt = 0, start_clr_snap = 0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                acc_cnt++;
                last_a = in_a;
                last_b = in_b;
                exp_q.push_back(model(in_a, in_b, core_hang));
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                out_log.push_back(out_product);
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_product", out_product, e.p);
                    chk("sb_flags", {out_bypass, out_err}, {e.byp, e.err});
                end
            end
            if (mul_start) begin start_cnt++; start_clr_snap = clr_cnt; end
            if (mul_clr) clr_cnt++;
        end
    end

    // ---------------- operation driver ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          input bit pulse_in, output logic [PW-1:0] p, output logic byp,
                          output logic er, output int lat);
        int n, acc0;
        n = 0;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        chk("in_ready_wait", in_ready, 1);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin @(negedge clk); lat++; end
        chk("out_valid_seen", out_valid, 1);
        p = out_product; byp = out_bypass; er = out_err;
        for (int i = 0; i < hold; i++) begin
            acc0 = acc_cnt;
            if (pulse_in) begin in_valid = (i % 2 == 0); in_a = 16'h1234; in_b = 16'h0002; end
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_product", out_product, p);
            chk("hold_flags", {out_bypass, out_err}, {byp, er});
            chk("hold_in_ready", in_ready, 0);
            chk("hold_no_accept", acc_cnt, acc0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0]  a, b;
        int            hold;
        bit            pulse;
        logic [PW-1:0] exp_p;
        logic          exp_byp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] p;
        logic byp, er;
        int lat, s0, c0, a0, o0, n;
        exp_t e;

        tbl[0] = '{a: 16'd5,     b: 16'd3,  hold: 0,  pulse: 0, exp_p: 16'd15,     exp_byp: 0};
        tbl[1] = '{a: 16'd0,     b: 16'd9,  hold: 0,  pulse: 0, exp_p: 16'd0,      exp_byp: 1};
        tbl[2] = '{a: 16'd7,     b: 16'd6,  hold: 10, pulse: 1, exp_p: 16'd42,     exp_byp: 0};
        tbl[3] = '{a: 16'd9,     b: 16'd0,  hold: 2,  pulse: 0, exp_p: 16'd0,      exp_byp: 1};
        tbl[4] = '{a: 16'hFFFF,  b: 16'd2,  hold: 1,  pulse: 0, exp_p: 16'hFFFE,   exp_byp: 0};
        tbl[5] = '{a: 16'd3,     b: 16'd11, hold: 0,  pulse: 0, exp_p: 16'd33,     exp_byp: 0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mul_clr", mul_clr, 1);
        chk("rst_outs", {out_valid, busy, mul_start, out_bypass, out_err}, 5'b0);
        chk("rst_product", out_product, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_mul_clr", mul_clr, 0);
        @(negedge clk);

        // vector table
        core_delay = 2;
        for (int i = 0; i < 6; i++) begin
            s0 = start_cnt;
            run_op(tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].pulse, p, byp, er, lat);
            chk("tbl_product", p, tbl[i].exp_p);
            chk("tbl_bypass", byp, tbl[i].exp_byp);
            chk("tbl_err", er, 0);
            chk("tbl_latency", 64'(lat), tbl[i].exp_byp ? 64'd0 : 64'(5 + core_delay));
            chk("tbl_start_pulses", 64'(start_cnt - s0), tbl[i].exp_byp ? 64'd0 : 64'd1);
            chk("tbl_clr_after_hs", mul_clr, !tbl[i].exp_byp);
            @(negedge clk);
            chk("tbl_clr_one_cycle", mul_clr, 0);
            chk("tbl_idle_ready", in_ready, 1);
        end

        // bus steering from idle with forced strobes (a_reg=3, b_reg=11)
        force_b = 1'b1; #1;
        chk("bus_b_only", mul_data, 16'd11);
        force_a = 1'b1; #1;
        chk("bus_a_priority", mul_data, 16'd3);
        force_b = 1'b0; #1;
        chk("bus_a_only", mul_data, 16'd3);
        force_a = 1'b0; #1;
        chk("bus_none", mul_data, 16'd0);
        @(negedge clk);

        // watchdog: core never finishes
        core_hang = 1'b1;
        run_op(16'd5, 16'd5, 1, 0, p, byp, er, lat);
        chk("to_latency", 64'(lat), 64'(1 + TO));
        chk("to_err", er, 1);
        chk("to_product", p, 0);
        chk("to_bypass", byp, 0);
        chk("to_clr_after_hs", mul_clr, 1);
        @(negedge clk);
        core_hang = 1'b0;

        // reset while waiting on the core
        core_hang = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        in_a = 16'd6; in_b = 16'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1; #1;
        chk("mid_rst_outs", {out_valid, busy, mul_start, in_ready, out_bypass, out_err}, 6'b0);
        chk("mid_rst_clr", mul_clr, 1);
        chk("mid_rst_product", out_product, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_hold_clr", mul_clr, 1);
            chk("mid_rst_hold_busy", busy, 0);
        end
        rst = 1'b0; core_hang = 1'b0; #1;
        chk("mid_rel_in_ready", in_ready, 1);
        chk("mid_rel_clr", mul_clr, 0);
        @(negedge clk);

        // back-to-back 7x6 then 4x4 with in_valid held high
        c0 = clr_cnt; a0 = acc_cnt; o0 = out_cnt; s0 = start_cnt;
        out_ready = 1'b1; in_valid = 1'b1; in_a = 16'd7; in_b = 16'd6;
        n = 0;
        while (acc_cnt == a0 && n < 50) begin @(negedge clk); n++; end
        in_a = 16'd4; in_b = 16'd4;
        n = 0;
        while (acc_cnt < a0 + 2 && n < 200) begin @(negedge clk); n++; end
        in_valid = 1'b0;
        n = 0;
        while (out_cnt < o0 + 2 && n < 200) begin @(negedge clk); n++; end
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_accepts", 64'(acc_cnt - a0), 2);
        chk("b2b_outputs", 64'(out_cnt - o0), 2);
        if (out_log.size() >= 2) begin
            chk("b2b_first", out_log[out_log.size() - 2], 16'd42);
            chk("b2b_second", out_log[out_log.size() - 1], 16'd16);
        end else begin
            chk("b2b_log_size", 64'(out_log.size()), 2);
        end
        chk("b2b_starts", 64'(start_cnt - s0), 2);
        chk("b2b_clr_before_2nd_start", 64'(start_clr_snap - c0), 1);
        chk("b2b_clr_total", 64'(clr_cnt - c0), 2);

        // randomized operations
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? 16'd0 : W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 16'd0 : W'($urandom_range(1, 12));
            core_delay = $urandom_range(0, 5);
            e = model(ra, rb, 1'b0);
            run_op(ra, rb, $urandom_range(0, 3), 1'b0, p, byp, er, lat);
            chk("rnd_product", p, e.p);
            chk("rnd_flags", {byp, er}, {e.byp, e.err});
            chk("rnd_latency", 64'(lat), e.byp ? 64'd0 : 64'(5 + core_delay));
        end
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_operand_sequencer.md
Name: mul_operand_sequencer

Overview:
- Upstream front end for the repeated-addition multiplier core (controller plus datapath).
- Accepts an operand pair over a valid/ready interface and starts the core.
- Steers A, then B, onto the core's shared data bus using the core's load strobes.
- Waits for done, captures the product, returns it over a valid/ready interface, then clears the core for the next operation.
- Zero operands bypass the core; a watchdog bounds the wait.

Parameters:
W, 16, operand width and core data-bus width
PW, 16, product width as produced by the core
TIMEOUT_CYC, 1024, maximum WAIT cycles before error; must be >= 2

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept an operand pair
in_a  in  W  multiplicand
in_b  in  W  multiplier (repeat count)
mul_start  out  1  start pulse to the core controller
mul_clr  out  1  returns the core controller to its idle state
mul_ld_a  in  1  core strobe: A being loaded
mul_ld_b  in  1  core strobe: B being loaded
mul_done  in  1  core done (level, sticky until mul_clr)
mul_product  in  PW  core product register
mul_data  out  W  shared data bus into the core
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_product  out  PW  result
out_bypass  out  1  result produced without using the core
out_err  out  1  watchdog expired; out_product is 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - All outputs 0 except mul_clr.
  - mul_clr is held 1 combinationally while rst is high.
  - State is IDLE; operand, result and counter registers are 0.
  - Reset mid-operation abandons the transaction with no output handshake.
- States: IDLE, START, WAIT, OUT, CLR.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_a/in_b into a_reg/b_reg.
  - If either operand is 0: result=0, bypass=1, go to OUT.
  - Otherwise go to START.
- START:
  - mul_start=1 for exactly one cycle.
  - Clear the watchdog counter, then go to WAIT.
- WAIT:
  - mul_done is sampled only in this state. A stale done seen in START is ignored.
  - When mul_done=1: capture mul_product into the result register, go to OUT.
  - The watchdog increments each cycle.
  - When the counter reaches TIMEOUT_CYC-1 with mul_done still 0: result=0, err=1, go to OUT.
  - If done and timeout occur in the same cycle, done wins.
- mul_data is combinational in all states:
  - a_reg if mul_ld_a;
  - else b_reg if mul_ld_b;
  - else 0.
  - If both strobes are high, a_reg wins.
- OUT:
  - out_valid=1. out_product, out_bypass and out_err are held stable until out_ready=1.
  - On handshake: go to CLR if the core was started, or to IDLE if the result was a bypass.
  - out_ready is ignored outside OUT.
- CLR: mul_clr=1 for one cycle, then go to IDLE. Flags clear on leaving OUT.
- in_ready=0 outside IDLE; in_valid is ignored there and no operand is dropped silently.
- Latency:
  - Bypass: out_valid rises one cycle after the accept edge.
  - Core path: mul_start in the cycle after accept; out_valid in the cycle after mul_done is sampled high.
  - Minimum back-to-back spacing: 1 cycle after a bypass handshake; 2 cycles after a core handshake.
- Width rule: the product is passed through unmodified. Overflow is the core's concern; the sequencer adds no saturation.

Test Plan:
- a=5, b=3, behavioural core model, out_ready=1 -> single mul_start pulse; mul_data=5 during ld_a and 3 during ld_b; out_product=15, bypass=0, err=0; one mul_clr pulse after handshake.
- a=0, b=9 -> mul_start never asserts; out_valid one cycle after accept; out_product=0, out_bypass=1; no mul_clr.
- a=7, b=6 with out_ready low for 10 cycles -> out_valid and out_product=42 held stable; in_ready=0 throughout; in_valid pulses in this window are not accepted.
- Core model never asserts done, TIMEOUT_CYC=64 -> out_valid exactly 64 cycles after entering WAIT; out_err=1, out_product=0; mul_clr pulse follows the handshake.
- rst asserted for 3 cycles while in WAIT -> all outputs at reset values immediately; mul_clr=1 during reset; in_ready=1 in the first cycle after release.
- Back-to-back 7×6 then 4×4, in_valid held high -> results 42 then 16 in order; mul_clr pulse between them; second mul_start only after CLR.
